// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-master data memory arbiter.
//   lock_owner_t : which master (if any) currently holds the memory lock
//   DEF_*_WIDTH  : system default address/data widths
package mem_arbiter2_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_M0   = 2'd1,
        LOCK_M1   = 2'd2
    } lock_owner_t;

endpackage

// File: rtl/mem_arbiter2_rr_pick2.sv
// Combinational 2-way round-robin picker, reusable for any shared resource.
//   req0, req1 : request lines
//   last       : winner of the previous grant (1 = requester 1)
//   gnt0, gnt1 : one-hot (or zero) grant
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    // On a tie the requester that did not win last time goes first.
    assign gnt0 = req0 & (~req1 | last);
    assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (m0)
// and a second bus master (m1), with a bounded lock for atomic sequences.
//   clock, reset          : clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata : master X request bundle
//   mX_grant              : access accepted this cycle (combinational)
//   mX_rvalid             : read data for master X valid this cycle
//   rdata                 : shared read data (pass-through of mem_rdata)
//   mem_we/addr/wdata     : memory access, mem_rdata returns one cycle later
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_grant,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_grant,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W  = $clog2(MAX_LOCK + 1);
    localparam int unsigned CNT_W1 = CNT_W + 1;

    logic              last;
    lock_owner_t       lock_own;
    logic [CNT_W-1:0]  lock_cnt;
    logic              rv0;
    logic              rv1;

    logic              rr_g0;
    logic              rr_g1;
    logic              gnt0;
    logic              gnt1;
    logic              win_lock;
    logic              other_req;
    logic              own_win;
    logic [CNT_W1-1:0] held_next;

    rr_pick2 u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last),
        .gnt0 (rr_g0),
        .gnt1 (rr_g1)
    );

    // Grant: lock owner first, then round-robin; nothing while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (lock_own == LOCK_M0 && m0_req) begin
            gnt0 = 1'b1;
        end else if (lock_own == LOCK_M1 && m1_req) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = rr_g0;
            gnt1 = rr_g1;
        end
    end

    assign m0_grant  = gnt0;
    assign m1_grant  = gnt1;
    assign mem_addr  = gnt1 ? m1_addr  : m0_addr;
    assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
    assign rdata     = mem_rdata;

    // A pending read is suppressed during the reset cycle itself.
    assign m0_rvalid = rv0 & ~reset;
    assign m1_rvalid = rv1 & ~reset;

    // Contested-hold count the winner would carry if it keeps the lock;
    // a fresh owner starts from zero, and the acquiring cycle counts.
    always_comb begin
        win_lock  = gnt1 ? m1_lock : m0_lock;
        other_req = gnt1 ? m0_req  : m1_req;
        own_win   = (gnt0 && lock_own == LOCK_M0) || (gnt1 && lock_own == LOCK_M1);
        held_next = (own_win ? {1'b0, lock_cnt} : CNT_W1'(0)) + CNT_W1'(other_req);
    end

    // Arbitration state: last winner, lock ownership, read-valid pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            last     <= 1'b1;
            lock_own <= LOCK_NONE;
            lock_cnt <= '0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
        end else begin
            rv0 <= gnt0 & ~m0_we;
            rv1 <= gnt1 & ~m1_we;
            if (gnt0 || gnt1) begin
                last <= gnt1;
            end
            if ((gnt0 || gnt1) && win_lock && (held_next < CNT_W1'(MAX_LOCK))) begin
                lock_own <= gnt1 ? LOCK_M1 : LOCK_M0;
                lock_cnt <= held_next[CNT_W-1:0];
            end else begin
                // Lock released: not requested, owner idle, or budget spent.
                lock_own <= LOCK_NONE;
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Self-checking bench for mem_arbiter2: external memory model, a cycle-level
// reference of the arbitration rules, and directed scenarios with literals.
module tb_mem_arbiter2;

    localparam int MAX_LOCK = 8;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m0_lock;
    logic [15:0] m0_addr, m0_wdata;
    logic        m0_grant, m0_rvalid;
    logic        m1_req, m1_we, m1_lock;
    logic [15:0] m1_addr, m1_wdata;
    logic        m1_grant, m1_rvalid;
    logic [15:0] rdata;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter2 #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .MAX_LOCK   (MAX_LOCK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_grant  (m0_grant),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_grant  (m1_grant),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External single-port memory, one-cycle read latency.
    logic [15:0] ext_mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ext_mem[i] = 16'(i) ^ 16'hA5A5;
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
        end
    end
    always @(posedge clock) begin
        if (mem_we) ext_mem[mem_addr] <= mem_wdata;
        mem_rdata <= ext_mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: -1 means "nobody".
    int          m_last  = 1;
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_pend  = -1;
    logic [15:0] m_pend_data = '0;

    logic        req_a  [2];
    logic        we_a   [2];
    logic        lock_a [2];
    logic [15:0] addr_a [2];
    logic [15:0] wd_a   [2];
    int          win;
    logic        exp_we;

    // Every-cycle comparison against the rule-level model.
    always @(negedge clock) begin
        req_a[0] = m0_req;  req_a[1] = m1_req;
        we_a[0]  = m0_we;   we_a[1]  = m1_we;
        lock_a[0] = m0_lock; lock_a[1] = m1_lock;
        addr_a[0] = m0_addr; addr_a[1] = m1_addr;
        wd_a[0]  = m0_wdata; wd_a[1]  = m1_wdata;

        win = -1;
        if (!reset) begin
            if (m_owner >= 0 && req_a[m_owner]) win = m_owner;
            else if (req_a[0] && req_a[1])      win = 1 - m_last;
            else if (req_a[0])                  win = 0;
            else if (req_a[1])                  win = 1;
        end
        exp_we = (win == 0 && m0_we) || (win == 1 && m1_we);

        check("model_g0", m0_grant, win == 0);
        check("model_g1", m1_grant, win == 1);
        check("model_we", mem_we, exp_we);
        check("model_addr", mem_addr, (win == 1) ? m1_addr : m0_addr);
        check("model_wdata", mem_wdata, (win == 1) ? m1_wdata : m0_wdata);
        check("model_rv0", m0_rvalid, !reset && m_pend == 0);
        check("model_rv1", m1_rvalid, !reset && m_pend == 1);
        if (!reset && m_pend >= 0) check("model_rdata", rdata, m_pend_data);

        if (reset) begin
            m_last = 1; m_owner = -1; m_held = 0; m_pend = -1;
        end else begin
            m_pend = -1;
            if (win >= 0) begin
                if (we_a[win]) ref_mem[addr_a[win]] = wd_a[win];
                else begin
                    m_pend = win;
                    m_pend_data = ref_mem[addr_a[win]];
                end
                if (lock_a[win]) begin
                    m_held  = ((m_owner == win) ? m_held : 0) + (req_a[1 - win] ? 1 : 0);
                    m_owner = win;
                    if (m_held >= MAX_LOCK) begin
                        m_owner = -1;
                        m_held  = 0;
                    end
                end else begin
                    m_owner = -1;
                    m_held  = 0;
                end
                m_last = win;
            end else begin
                m_owner = -1;
                m_held  = 0;
            end
        end
    end

    int lock_seq [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 16'h0010; m0_wdata = 16'h0000;
        m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 16'h0020; m1_wdata = 16'h0000;

        // Reset held two cycles with both requesting.
        repeat (2) begin
            @(negedge clock);
            check("rst_g0", m0_grant, 0);
            check("rst_g1", m1_grant, 0);
            check("rst_we", mem_we, 0);
            check("rst_rv0", m0_rvalid, 0);
            check("rst_rv1", m1_rvalid, 0);
        end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("first_tie_g0", m0_grant, 1);
        check("first_tie_g1", m1_grant, 0);

        // Continuous reads alternate; data returns one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("alt_g1", m1_grant, (i % 2) == 0);
            check("alt_g0", m0_grant, (i % 2) == 1);
            if (i % 2 == 0) begin
                check("alt_rv0", m0_rvalid, 1);
                check("alt_rv1", m1_rvalid, 0);
                check("alt_rdata0", rdata, 16'hA5B5);
            end else begin
                check("alt_rv1", m1_rvalid, 1);
                check("alt_rv0", m0_rvalid, 0);
                check("alt_rdata1", rdata, 16'hA585);
            end
        end

        // m1 alone writes 0xBEEF to 0x0005.
        @(posedge clock); #1
        m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0005; m1_wdata = 16'hBEEF;
        @(negedge clock);
        check("wr_g1", m1_grant, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 16'h0005);
        check("wr_wdata", mem_wdata, 16'hBEEF);
        check("wr_prev_rv0", m0_rvalid, 1);
        check("wr_prev_rdata", rdata, 16'hA5B5);
        @(posedge clock); #1
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0020; m1_wdata = 16'h0000;
        @(negedge clock);
        check("wr_no_rv1", m1_rvalid, 0);
        check("idle_we", mem_we, 0);
        @(posedge clock); #1 m0_req = 1'b1; m0_addr = 16'h0005;
        @(negedge clock);
        check("rb_g0", m0_grant, 1);
        @(posedge clock); #1 m0_req = 1'b0; m0_addr = 16'h0010;
        @(negedge clock);
        check("rb_rv0", m0_rvalid, 1);
        check("rb_rdata", rdata, 16'hBEEF);

        // Bounded lock: m1 read first so m0 wins the opening tie.
        @(posedge clock); #1 m1_req = 1'b1;
        @(negedge clock);
        check("pre_lock_g1", m1_grant, 1);
        @(posedge clock); #1 m0_req = 1'b1; m0_lock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check("lock_seq_g0", m0_grant, lock_seq[i] == 0);
            check("lock_seq_g1", m1_grant, lock_seq[i] == 1);
            if (i == 8) begin
                @(posedge clock); #1 m0_lock = 1'b0;
            end
        end

        // Locked owner drops req for a cycle: m1 gets it, lock is gone.
        @(posedge clock); #1 m1_req = 1'b0; m0_req = 1'b1; m0_lock = 1'b1;
        @(negedge clock);
        check("own_g0", m0_grant, 1);
        @(posedge clock); #1 m0_req = 1'b0; m1_req = 1'b1;
        @(negedge clock);
        check("own_idle_g1", m1_grant, 1);
        check("own_idle_g0", m0_grant, 0);
        @(posedge clock); #1 m0_req = 1'b1; m0_lock = 1'b0;
        @(negedge clock);
        check("after_idle_g0", m0_grant, 1);

        // Read granted, then reset: no rvalid, m0 wins first tie after.
        @(posedge clock); #1 m1_req = 1'b0; m0_lock = 1'b1;
        @(negedge clock);
        check("pre_rst_g0", m0_grant, 1);
        @(posedge clock); #1 reset = 1'b1; m1_req = 1'b1;
        @(negedge clock);
        check("mid_rst_rv0", m0_rvalid, 0);
        check("mid_rst_g0", m0_grant, 0);
        check("mid_rst_g1", m1_grant, 0);
        @(posedge clock); #1 reset = 1'b0; m0_lock = 1'b0;
        @(negedge clock);
        check("post_rst_g0", m0_grant, 1);
        check("post_rst_g1", m1_grant, 0);

        // Lock held by m1 must not survive reset.
        @(posedge clock); #1 m0_req = 1'b0; m1_lock = 1'b1;
        @(negedge clock);
        check("m1_lock_g1", m1_grant, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("m1_rst_g1", m1_grant, 0);
        @(posedge clock); #1 reset = 1'b0; m0_req = 1'b1; m1_lock = 1'b0;
        @(negedge clock);
        check("m1_post_g0", m0_grant, 1);
        check("m1_post_g1", m1_grant, 0);

        @(posedge clock); #1 m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
Name: mem_arbiter2

Overview:
Two-requester arbiter that shares the single-port data memory (the data memory with I/O mapping) between the CPU and a second bus master, such as a DMA or display fetch engine. It issues at most one access per clock and uses round-robin priority with an optional bounded lock for atomic sequences. It returns read data with fixed one-cycle latency and a per-requester valid strobe. It sits between the cpu/peripheral ports and the data memory inside the top-level system module.

Parameters:
ADDR_WIDTH, 16, address width of requesters and memory
DATA_WIDTH, 16, data word width
MAX_LOCK, 8, max consecutive cycles a locking owner may hold the memory while the other side is requesting

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
m0_req  input  1  CPU access request (held until granted)
m0_we  input  1  CPU write enable (valid with m0_req)
m0_lock  input  1  CPU requests to keep ownership next cycle
m0_addr  input  ADDR_WIDTH  CPU address
m0_wdata  input  DATA_WIDTH  CPU write data
m0_grant  output  1  CPU access accepted this cycle (combinational)
m0_rvalid  output  1  read data for CPU valid this cycle
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_grant, m1_rvalid  same as m0_*, for the second master
rdata  output  DATA_WIDTH  read data, shared; qualified by mX_rvalid
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after address

Behaviour:
- State registers: last (winner of most recent grant), lock_own (none/m0/m1), lock_cnt (clog2(MAX_LOCK+1) bits), rv0, rv1.
- Reset values: last=1 (so m0 wins the first tie), lock_own=none, lock_cnt=0, rv0=rv1=0. The grant outputs follow the rule below, and reset forces them to 0: while reset=1 both grants=0 and mem_we=0.
- Arbitration, combinational each cycle, in priority order:
  1. If lock_own=mX and mX_req=1, grant mX.
  2. Otherwise, if only one req is high, grant it.
  3. If both are high, grant the one not equal to last.
  4. If neither is high, grant none.
- Mux: mem_addr/mem_wdata follow the granted master. If none is granted, mem_addr holds the m0 value and mem_wdata holds m0_wdata. mem_we = granted master's we AND grant; it is never 1 without a grant.
- Registered updates on grant to mX: last<=X; rvX<=~mX_we (the other rv<=0). With no grant, rv0=rv1=0.
- Read latency: mX_rvalid=rvX, asserted exactly 1 cycle after the granted read. rdata = mem_rdata (pass-through, no extra register). Writes produce no rvalid.
- Lock:
  - Granted mX with mX_lock=1: lock_own<=X.
  - Cycle where the locked owner is granted while the other req=1: lock_cnt increments.
  - When lock_cnt reaches MAX_LOCK: lock_own<=none and lock_cnt<=0. The other master then wins the next contested cycle via round-robin (last=X).
  - Owner grant with mX_lock=0, or owner req=0: lock_own<=none, lock_cnt<=0.
  - lock_cnt resets to 0 on any ownership change.
- Lock-held idle: if lock_own=mX and mX_req=0, the other master may be granted that same cycle and the lock is dropped.
- Simultaneous events: a write and a read in the same cycle are impossible, because one grant is issued per cycle. A locked master's grant outranks round-robin.
- Reset mid-operation: pending rvalid is cleared (a read granted in the reset cycle returns no rvalid) and the lock is dropped.
- Requesters must hold req/we/addr/wdata stable until grant. Behaviour is undefined otherwise, and the bench does not test it.

Decomposition:
- Shared package holds:
  - lock_owner enumeration (LOCK_NONE, LOCK_M0, LOCK_M1)
  - ADDR_WIDTH and DATA_WIDTH defaults for the system
- One natural sub-module, rr_pick2: combinational 2-way round-robin picker (req0, req1, last -> gnt0, gnt1). It is reusable for other shared resources.

Test Plan:
1. Reset held 2 cycles with both req=1 -> grants=0, mem_we=0, rvalid=0. First cycle after reset, both req -> m0_grant=1.
2. Both masters request reads continuously, m0_addr=0x0010, m1_addr=0x0020 -> grants alternate m0,m1,m0,m1. Each mX_rvalid arrives exactly 1 cycle after its grant, with rdata=mem contents at that address.
3. m1 alone writes 0xBEEF to 0x0005 (m1_we=1) -> m1_grant=1 same cycle, mem_we=1, mem_addr=0x0005, mem_wdata=0xBEEF, no m1_rvalid next cycle.
4. m0 holds lock=1 with req every cycle while m1_req=1 (MAX_LOCK=8) -> m0 granted 8 consecutive cycles, m1 granted on cycle 9, then alternation resumes.
5. m0 read granted, then reset asserted next cycle -> m0_rvalid=0 in that cycle, lock_own=none, and m0 wins the first tie after reset.
6. m0 locked but drops req for one cycle while m1_req=1 -> m1 granted that cycle, and a subsequent contested cycle grants m0 (last=1).
